// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// request in flight, and feeds the IF/ID register. A one-entry skid buffer
// absorbs decode stalls. A redirect that arrives while a response is still
// outstanding is held in pend_pc until the stale response has been drained.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            ifid_en_o,
  output logic            ifid_clr_o
);

  // REQ: request in flight for req_addr
  // DROP: stale response still owed by memory; the redirect target waits in pend_pc
  // BUF: response captured in buf_instr while decode was stalled
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DROP = 2'd1,
    S_BUF  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] req_addr, req_addr_n;
  logic [XLEN-1:0] pend_pc, pend_pc_n;
  logic [31:0]     buf_instr, buf_instr_n;
  logic [XLEN-1:0] next_pc;

  // Sequential PC; wraps modulo 2^XLEN.
  assign next_pc     = req_addr + XLEN'(4);
  assign imem_addr_o = req_addr;

  // State and fetch registers; an asynchronous reset abandons any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_REQ;
      req_addr  <= RESET_PC;
      pend_pc   <= '0;
      buf_instr <= '0;
    end else begin
      state     <= state_n;
      req_addr  <= req_addr_n;
      pend_pc   <= pend_pc_n;
      buf_instr <= buf_instr_n;
    end
  end

  // Next-state and IF/ID control. Redirect beats stall everywhere; when nothing
  // is delivered and decode is not stalled, IF/ID is cleared to insert a bubble.
  always_comb begin
    state_n     = state;
    req_addr_n  = req_addr;
    pend_pc_n   = pend_pc;
    buf_instr_n = buf_instr;
    imem_req_o  = 1'b0;
    ifid_en_o   = 1'b0;
    ifid_clr_o  = 1'b0;
    if_instr_o  = '0;
    if_pc_o     = '0;

    if (rst) begin
      ifid_clr_o = 1'b1;
    end else begin
      case (state)
        S_REQ: begin
          imem_req_o = 1'b1;
          if (imem_rvalid_i && redirect_valid_i) begin
            ifid_clr_o = 1'b1;
            req_addr_n = redirect_pc_i;
          end else if (imem_rvalid_i && stall_i) begin
            buf_instr_n = imem_rdata_i;
            state_n     = S_BUF;
          end else if (imem_rvalid_i) begin
            ifid_en_o  = 1'b1;
            if_instr_o = imem_rdata_i;
            if_pc_o    = req_addr;
            req_addr_n = next_pc;
          end else if (redirect_valid_i) begin
            pend_pc_n  = redirect_pc_i;
            ifid_clr_o = 1'b1;
            state_n    = S_DROP;
          end else if (!stall_i) begin
            ifid_clr_o = 1'b1;
          end
        end

        S_DROP: begin
          // Address stays put until memory hands back the response we will discard.
          imem_req_o = 1'b1;
          ifid_clr_o = !stall_i || redirect_valid_i;
          if (imem_rvalid_i) begin
            req_addr_n = redirect_valid_i ? redirect_pc_i : pend_pc;
            state_n    = S_REQ;
          end else if (redirect_valid_i) begin
            pend_pc_n = redirect_pc_i;
          end
        end

        S_BUF: begin
          // req_addr still names the buffered instruction.
          if (redirect_valid_i) begin
            ifid_clr_o = 1'b1;
            req_addr_n = redirect_pc_i;
            state_n    = S_REQ;
          end else if (!stall_i) begin
            ifid_en_o  = 1'b1;
            if_instr_o = buf_instr;
            if_pc_o    = req_addr;
            req_addr_n = next_pc;
            state_n    = S_REQ;
          end
        end

        default: begin
          state_n = S_REQ;
        end
      endcase
    end
  end

endmodule
